// File: rtl/ad_capture_ctrl_if.sv
// Read-out port of the capture sequencer: the requester drives rd_en and gets data one cycle later.
// master = sample source (the sequencer), slave = display/host consumer.
interface ad_capture_ctrl_if #(
  parameter int DW = 12
);
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_last;

  modport master (input rd_en, output rd_data, rd_valid, rd_last);
  modport slave  (output rd_en, input rd_data, rd_valid, rd_last);
endinterface

// File: rtl/ad_capture_ctrl.sv
// Pre/post-trigger capture of ad_ch1 into a circular RAM of 2**AW samples, then window readout.
// Read data lags rd_en by one cycle; rd_en low simply pauses the stream.
module ad_capture_ctrl #(
  parameter int DW = 12,
  parameter int AW = 10
) (
  input  logic          ad_clk,
  input  logic          rst,
  input  logic [DW-1:0] ad_ch1,
  input  logic          arm,
  input  logic          force_trig,
  input  logic [DW-1:0] trig_level,
  input  logic          trig_slope,
  input  logic [AW-1:0] pre_len,
  output logic          busy,
  output logic          triggered,
  output logic          done,
  output logic [AW-1:0] trig_ptr,
  ad_capture_ctrl_if.master rd
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] prev_sample;
  logic [AW-1:0] wr_ptr, cnt, plen, rd_ptr;
  logic [AW:0]   rd_cnt;
  logic          wr_en, trig_hit, arm_go, rd_go;
  logic          rise_hit, fall_hit;

  assign rise_hit = (prev_sample <  trig_level) && (ad_ch1 >= trig_level);
  assign fall_hit = (prev_sample >= trig_level) && (ad_ch1 <  trig_level);

  assign busy = state inside {S_PRE, S_WAIT, S_POST};
  assign done = (state == S_DONE);

  always_ff @(posedge ad_clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    trig_hit  = 1'b0;
    arm_go    = 1'b0;
    rd_go     = 1'b0;
    case (state)
      S_IDLE: begin
        if (arm) begin
          arm_go    = 1'b1;
          state_nxt = (pre_len == '0) ? S_WAIT : S_PRE;
        end
      end
      S_PRE: begin
        wr_en = 1'b1;
        if (cnt == plen - AW'(1)) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        wr_en = 1'b1;
        if (force_trig || (trig_slope ? rise_hit : fall_hit)) begin
          trig_hit  = 1'b1;
          // plen == DEPTH-1 leaves no post-trigger samples to collect
          state_nxt = (plen == '1) ? S_DONE : S_POST;
        end
      end
      S_POST: begin
        wr_en = 1'b1;
        if (cnt == AW'(1)) state_nxt = S_DONE;
      end
      S_DONE: begin
        rd_go = rd.rd_en && (rd_cnt < (AW+1)'(DEPTH));
        if (arm) begin
          arm_go    = 1'b1;
          state_nxt = (pre_len == '0) ? S_WAIT : S_PRE;
        end else if (rd.rd_valid && rd.rd_last) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ad_clk) begin
    if (wr_en && !rst) mem[wr_ptr] <= ad_ch1;
  end

  always_ff @(posedge ad_clk) begin
    if (rst) begin
      prev_sample <= '0;
      wr_ptr      <= '0;
      cnt         <= '0;
      plen        <= '0;
      trig_ptr    <= '0;
      rd_ptr      <= '0;
      rd_cnt      <= '0;
      triggered   <= 1'b0;
      rd.rd_data  <= '0;
      rd.rd_valid <= 1'b0;
      rd.rd_last  <= 1'b0;
    end else begin
      prev_sample <= ad_ch1;
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (state == S_PRE)  cnt <= cnt + AW'(1);
      if (state == S_POST) cnt <= cnt - AW'(1);
      if (arm_go) begin
        wr_ptr    <= '0;
        cnt       <= '0;
        plen      <= pre_len;
        triggered <= 1'b0;
      end
      if (trig_hit) begin
        trig_ptr  <= wr_ptr;
        cnt       <= ~plen;
        triggered <= 1'b1;
        rd_ptr    <= wr_ptr - plen;
        rd_cnt    <= '0;
      end
      if (state == S_DONE && state_nxt == S_IDLE) triggered <= 1'b0;
      rd.rd_valid <= rd_go;
      // a beat still in flight when a re-arm lands never closes the window
      rd.rd_last  <= rd_go && (rd_cnt == (AW+1)'(DEPTH - 1)) && !arm;
      if (rd_go) begin
        rd.rd_data <= mem[rd_ptr];
        rd_ptr     <= rd_ptr + AW'(1);
        rd_cnt     <= rd_cnt + (AW+1)'(1);
      end
    end
  end

endmodule

// File: doc/ad_capture_ctrl.md
Name: ad_capture_ctrl

Overview:
- Acquisition sequencer for the 12-bit ADC capture channel.
- Takes the registered sample word ad_ch1 on every ad_clk cycle and writes it into an internal circular sample RAM.
- Detects a level/slope trigger, then freezes a window of DEPTH samples that includes a programmable pre-trigger length.
- Streams the frozen window out through a read handshake for display or host transfer.

Parameters:
- DW, 12, sample width in bits; matches ad_ch1.
- AW, 10, RAM address width; DEPTH = 2**AW samples.

Ports:
- ad_clk  input  1  sample clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- ad_ch1  input  DW  sample word; treated as a new sample every cycle.
- arm  input  1  single-cycle pulse; starts a capture.
- force_trig  input  1  trigger immediately, regardless of level.
- trig_level  input  DW  unsigned trigger threshold.
- trig_slope  input  1  1 = rising edge, 0 = falling edge.
- pre_len  input  AW  number of pre-trigger samples; sampled when arm is accepted.
- busy  output  1  high in PRE, WAIT and POST.
- triggered  output  1  high from the cycle after trigger acceptance until return to IDLE.
- done  output  1  high in DONE (window frozen, readable).
- trig_ptr  output  AW  RAM address of the trigger sample.
- rd_en  input  1  read request; honoured only in DONE.
- rd_data  output  DW  sample read out.
- rd_valid  output  1  rd_data is valid this cycle.
- rd_last  output  1  qualifies the final sample of the window.

Behaviour:
- Reset (synchronous, active-high; rst overrides all other inputs):
  - busy, triggered, done, rd_valid, rd_last, trig_ptr and rd_data are all 0.
  - State goes to IDLE; prev_sample is 0.
  - RAM contents are don't-care.
  - rst mid-capture or mid-readout aborts the operation. The next arm starts a fresh capture.
- prev_sample register: loads ad_ch1 every cycle in every state. It supplies the previous sample for edge detection.
- Write path: in PRE, WAIT and POST, ad_ch1 is written to RAM[wr_ptr] each cycle and wr_ptr increments modulo DEPTH. No writes occur in IDLE or DONE.
- States:
  - IDLE:
    - arm -> PRE.
    - On arm, wr_ptr=0 and cnt=0, and pre_len is latched into plen.
    - If plen=0, the next state is WAIT directly.
  - PRE:
    - Write every cycle, cnt++.
    - When cnt reaches plen-1 in the same cycle as a write -> WAIT.
    - Triggers are ignored in PRE.
  - WAIT:
    - Write every cycle (circular overwrite).
    - Rising trigger: prev_sample < trig_level and ad_ch1 >= trig_level.
    - Falling trigger: prev_sample >= trig_level and ad_ch1 < trig_level.
    - force_trig=1 is also a trigger.
    - On trigger, the current sample is written at wr_ptr and trig_ptr is latched to that wr_ptr. cnt is loaded with DEPTH-1-plen remaining samples, then -> POST. If that count is 0, go directly to DONE.
  - POST:
    - Write every cycle, cnt--.
    - The write made when cnt reaches 1 is the final write -> DONE.
    - The total window is exactly DEPTH samples: plen before the trigger, then the trigger sample, then DEPTH-1-plen after it.
  - DONE:
    - done=1 and rd_ptr = trig_ptr - plen (mod DEPTH), i.e. the oldest sample of the window.
    - Each cycle with rd_en=1 issues a RAM read at rd_ptr and rd_ptr++ (mod DEPTH).
    - rd_data and rd_valid appear 1 cycle after the request (RAM latency 1).
    - rd_en=0 stalls the stream without losing data.
    - The DEPTH-th data beat carries rd_last=1. The state returns to IDLE in the same cycle as that beat, so done falls the cycle after.
    - Requests beyond DEPTH are ignored.
- arm handling:
  - Ignored in PRE, WAIT and POST.
  - In DONE, arm abandons readout and restarts the capture exactly as from IDLE. An outstanding read beat may still emit rd_valid the following cycle, with rd_last=0.
- Simultaneous events:
  - rst wins over everything.
  - force_trig combined with a level trigger counts as a single trigger.
  - rd_en outside DONE is ignored.
- Width rules: comparisons are unsigned at DW bits; all pointer arithmetic wraps at AW bits.

Test Plan:
- Basic rising trigger (AW=4, DEPTH 16, pre_len=4, trig_slope=1, trig_level=12'h800, ramp ad_ch1 = 0x7F0 + 4*n):
  - Arm, then let the ramp run.
  - Trigger fires on the first sample >= 0x800.
  - Readout returns 16 consecutive ramp values, with the 5th equal to the trigger sample.
  - rd_last is on beat 16; done falls the cycle after.
- Falling slope (trig_slope=0, level 0x400, ad_ch1 steps 0x500 -> 0x3FF):
  - Trigger fires on the 0x3FF sample.
  - No trigger while the signal stays constant below the level.
- Pre-fill masking:
  - Level crossing presented during PRE is not accepted as a trigger.
  - The first crossing after the PRE -> WAIT transition is accepted.
- Boundary lengths:
  - pre_len=0: the trigger sample is readout beat 1.
  - pre_len=15 (DEPTH-1): DONE is reached the cycle after the trigger, and the trigger sample is beat 16.
  - force_trig with wrap-around: trig_ptr=3 and pre_len=8 give read start address 11.
- Read stall:
  - Toggle rd_en 1,0,0,1,...
  - Exactly 16 rd_valid beats, data in order, none duplicated or dropped.
- Reset and re-arm:
  - rst asserted in POST -> all outputs 0 on the next cycle.
  - arm in DONE mid-readout -> busy on the next cycle and a complete new window captured.
